ps2_tx: RTL and testbench

PS/2 host-to-device transmitter for the Game of Life keyboard path. It serializes the 16-bit command packet `ps2_pkt_HD` (strobed by `send_ps2_pkt`) onto the PS/2 open-collector clock and data lines, following the host-request protocol, and checks the device ACK bit. It is the outbound counterpart of the receive path that feeds `ps2_pkt_DH`/`rec_ps2_pkt` into `ps2_parse`, and it is instantiated next to `ps2_parse` in `gol_top`.

---
 rtl/ps2_tx.sv | 198 +++++++++++++++++++
 tb/tb_ps2_tx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: sends a one- or two-byte command packet using the
// host-request protocol and checks the device ACK bit of each byte.
module ps2_tx #(
   parameter int INHIBIT_CYC = 5000,
   parameter int GAP_CYC     = 100000,
   parameter int TIMEOUT_CYC = 750000
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic [15:0] ps2_pkt_HD,
   input  logic        send_ps2_pkt,
   input  logic        ps2_clk_in,
   input  logic        ps2_data_in,
   output logic        ps2_clk_oe,
   output logic        ps2_data_oe,
   output logic        tx_busy,
   output logic        tx_done,
   output logic        tx_err
);

   localparam int CNT_MAX = (INHIBIT_CYC > GAP_CYC) ? INHIBIT_CYC : GAP_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int TW      = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYC - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_GAP
   } state_t;

   state_t          r_state, w_state_nxt;
   logic            r_clk_s1, r_clk_s2, r_clk_d;
   logic            r_dat_s1, r_dat_s2;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic [TW-1:0]   r_tmo, w_tmo_nxt;
   logic [3:0]      r_bitcnt, w_bitcnt_nxt;
   logic            r_idx, w_idx_nxt;
   logic [15:0]     r_pkt, w_pkt_nxt;
   logic            r_acked, w_acked_nxt;
   logic            r_clk_oe, w_clk_oe_nxt;
   logic            r_data_oe, w_data_oe_nxt;
   logic            r_done, w_done_nxt;
   logic            r_err, w_err_nxt;

   logic            w_fe;
   logic            w_has_hi;
   logic            w_more;
   logic [7:0]      w_byte;

   assign w_fe     = r_clk_d & ~r_clk_s2;
   assign w_has_hi = (r_pkt[15:8] != 8'h00);
   assign w_more   = ~r_idx & w_has_hi;
   assign w_byte   = w_more ? r_pkt[15:8] : r_pkt[7:0];

   assign ps2_clk_oe  = r_clk_oe;
   assign ps2_data_oe = r_data_oe;
   assign tx_busy     = (r_state != S_IDLE);
   assign tx_done     = r_done;
   assign tx_err      = r_err;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_clk_s1  <= 1'b0;
         r_clk_s2  <= 1'b0;
         r_clk_d   <= 1'b0;
         r_dat_s1  <= 1'b0;
         r_dat_s2  <= 1'b0;
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_tmo     <= '0;
         r_bitcnt  <= '0;
         r_idx     <= 1'b0;
         r_pkt     <= '0;
         r_acked   <= 1'b0;
         r_clk_oe  <= 1'b0;
         r_data_oe <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_clk_s1  <= ps2_clk_in;
         r_clk_s2  <= r_clk_s1;
         r_clk_d   <= r_clk_s2;
         r_dat_s1  <= ps2_data_in;
         r_dat_s2  <= r_dat_s1;
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_tmo     <= w_tmo_nxt;
         r_bitcnt  <= w_bitcnt_nxt;
         r_idx     <= w_idx_nxt;
         r_pkt     <= w_pkt_nxt;
         r_acked   <= w_acked_nxt;
         r_clk_oe  <= w_clk_oe_nxt;
         r_data_oe <= w_data_oe_nxt;
         r_done    <= w_done_nxt;
         r_err     <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_tmo_nxt     = r_tmo;
      w_bitcnt_nxt  = r_bitcnt;
      w_idx_nxt     = r_idx;
      w_pkt_nxt     = r_pkt;
      w_acked_nxt   = r_acked;
      w_clk_oe_nxt  = r_clk_oe;
      w_data_oe_nxt = r_data_oe;
      w_done_nxt    = 1'b0;
      w_err_nxt     = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_clk_oe_nxt  = 1'b0;
            w_data_oe_nxt = 1'b0;
            if (send_ps2_pkt) begin
               w_pkt_nxt    = ps2_pkt_HD;
               w_idx_nxt    = 1'b0;
               w_cnt_nxt    = '0;
               w_clk_oe_nxt = 1'b1;
               w_state_nxt  = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            if (r_cnt == INH_LAST) begin
               // Clock released and data pulled in the same edge: the request/start bit.
               w_clk_oe_nxt  = 1'b0;
               w_data_oe_nxt = 1'b1;
               w_bitcnt_nxt  = '0;
               w_tmo_nxt     = '0;
               w_acked_nxt   = 1'b0;
               w_state_nxt   = S_REQ;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_REQ, S_SHIFT: begin
            w_tmo_nxt = r_tmo + 1'b1;
            if (w_fe) begin
               w_bitcnt_nxt = r_bitcnt + 1'b1;
               w_state_nxt  = S_SHIFT;
               if (r_bitcnt <= 4'd7) begin
                  w_data_oe_nxt = ~w_byte[r_bitcnt[2:0]];
               end else if (r_bitcnt == 4'd8) begin
                  // Odd parity bit is ~^byte; the line is pulled when it is 0.
                  w_data_oe_nxt = ^w_byte;
               end else begin
                  w_data_oe_nxt = 1'b0;
                  w_state_nxt   = S_ACK;
               end
            end
         end
         S_ACK: begin
            w_tmo_nxt = r_tmo + 1'b1;
            if (!r_acked) begin
               if (w_fe) begin
                  if (!r_dat_s2) begin
                     w_acked_nxt = 1'b1;
                  end else begin
                     w_err_nxt   = 1'b1;
                     w_state_nxt = S_IDLE;
                  end
               end
            end else if (r_clk_s2) begin
               if (w_more) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_GAP;
               end else begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_GAP: begin
            if (r_cnt == GAP_LAST) begin
               w_cnt_nxt    = '0;
               w_idx_nxt    = 1'b1;
               w_clk_oe_nxt = 1'b1;
               w_state_nxt  = S_INHIBIT;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // Timeout overrides anything decided above, including an ACK/NACK on the same edge.
      if ((r_state == S_REQ || r_state == S_SHIFT || r_state == S_ACK) && r_tmo == TMO_LAST) begin
         w_state_nxt   = S_IDLE;
         w_clk_oe_nxt  = 1'b0;
         w_data_oe_nxt = 1'b0;
         w_done_nxt    = 1'b0;
         w_err_nxt     = 1'b1;
      end
   end

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx: a small PS/2 device model clocks bytes out of the host
// and each result is checked against hand-computed wire bits and cycle counts.
module tb_ps2_tx;

   localparam int INH = 10;
   localparam int GAP = 40;
   localparam int TMO = 2000;

   logic        clk = 1'b0;
   logic        rst_b = 1'b0;
   logic [15:0] pkt = 16'h0000;
   logic        send = 1'b0;
   logic        dev_clk_low = 1'b0;
   logic        dev_data_low = 1'b0;
   logic        ps2_clk_in, ps2_data_in;
   logic        ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err;

   int checks = 0, errors = 0;
   int done_cnt = 0, err_cnt = 0, glitch_cnt = 0, align_bad = 0;

   assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

   ps2_tx #(.INHIBIT_CYC(INH), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst_b(rst_b), .ps2_pkt_HD(pkt), .send_ps2_pkt(send),
      .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
      .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tx_done) done_cnt <= done_cnt + 1;
      if (tx_err) err_cnt <= err_cnt + 1;
      if (ps2_clk_oe && ps2_data_oe) glitch_cnt <= glitch_cnt + 1;
      if ((tx_done || tx_err) && tx_busy) align_bad <= align_bad + 1;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [15:0] p);
      @(negedge clk);
      pkt = p;
      send = 1'b1;
      @(posedge clk);
      #1 send = 1'b0;
      chk("start_busy", tx_busy, 1);
      chk("start_clk_oe", ps2_clk_oe, 1);
      chk("start_data_oe", ps2_data_oe, 0);
   endtask

   // Called in the first cycle the clock is held low; stops in the handover cycle.
   task automatic wait_req();
      int inh = 1;
      bit seen = 1'b0;
      for (int i = 0; i < INH + 20 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (ps2_data_oe && !ps2_clk_oe) seen = 1'b1;
         else if (ps2_clk_oe) inh++;
      end
      chk("req_seen", seen, 1);
      chk("inhibit_len", inh, INH);
   endtask

   // exp[i] is the wire level the host must present after device fall i+1 (stop in bit 9).
   task automatic dev_byte(input logic [9:0] exp, input logic ack, input int nfe);
      logic [9:0] wb = '0;
      logic       e_prev, e_new;
      for (int n = 1; n <= nfe; n++) begin
         repeat (4) @(negedge clk);
         if (n == 11) begin
            dev_data_low = ack;
            repeat (2) @(negedge clk);
         end
         e_prev = (n == 1) ? 1'b1 : ~exp[n-2];
         e_new  = (n <= 10) ? ~exp[n-1] : 1'b0;
         dev_clk_low = 1'b1;
         @(posedge clk);
         @(posedge clk);
         #1 chk("oe_hold_2cyc", ps2_data_oe, e_prev);
         @(posedge clk);
         #1 chk("oe_at_3cyc", ps2_data_oe, e_new);
         repeat (3) @(negedge clk);
         dev_clk_low = 1'b0;
         if (n <= 10) wb[n-1] = ps2_data_in;
         if (n == 11) dev_data_low = 1'b0;
      end
      if (nfe == 11) chk("wire_bits", wb, exp);
   endtask

   initial begin
      int  k, d0, e0, busy_lines;
      bit  seen;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_clk_oe", ps2_clk_oe, 0);
      chk("rst_data_oe", ps2_data_oe, 0);
      chk("rst_busy", tx_busy, 0);
      chk("rst_done", tx_done, 0);
      chk("rst_err", tx_err, 0);
      @(negedge clk) rst_b = 1'b1;
      repeat (3) @(posedge clk);

      // Two-byte send ED then 02, with an ignored 1234 strobe while busy
      d0 = done_cnt;
      start(16'hED02);
      wait_req();
      @(negedge clk);
      pkt = 16'h1234;
      send = 1'b1;
      @(negedge clk) send = 1'b0;
      chk("busy_strobe_busy", tx_busy, 1);
      dev_byte({1'b1, 1'b1, 8'hED}, 1'b1, 11);
      // 2 sync stages + 1 state edge before GAP starts counting
      k = 0;
      seen = 1'b0;
      for (int i = 0; i < GAP + 20 && !seen; i++) begin
         @(posedge clk);
         #1 k++;
         if (ps2_clk_oe) seen = 1'b1;
      end
      chk("gap_cycles", k, GAP + 3);
      chk("no_done_between", done_cnt, d0);
      wait_req();
      dev_byte({1'b1, 1'b0, 8'h02}, 1'b1, 11);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(posedge clk);
         #1 if (tx_done) seen = 1'b1;
      end
      chk("two_byte_done", seen, 1);
      chk("busy_low_with_done", tx_busy, 0);
      @(posedge clk);
      #1 chk("done_one_pulse", done_cnt, d0 + 1);

      // Single-byte mode: 00FF sends only FF
      d0 = done_cnt;
      start(16'h00FF);
      wait_req();
      dev_byte({1'b1, 1'b1, 8'hFF}, 1'b1, 11);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(posedge clk);
         #1 if (tx_done) seen = 1'b1;
      end
      chk("single_done", seen, 1);
      chk("single_busy_low", tx_busy, 0);

      // Back-to-back strobe in the done cycle, then NACK on the first byte
      e0 = err_cnt;
      start(16'hED02);
      chk("single_done_count", done_cnt, d0 + 1);
      wait_req();
      dev_byte({1'b1, 1'b1, 8'hED}, 1'b0, 11);
      chk("nack_err", err_cnt, e0 + 1);
      chk("nack_busy", tx_busy, 0);
      busy_lines = 0;
      for (int i = 0; i < GAP + 30; i++) begin
         @(posedge clk);
         #1 if (ps2_clk_oe || ps2_data_oe || tx_busy) busy_lines++;
      end
      chk("nack_no_second", busy_lines, 0);
      chk("nack_no_done", done_cnt, d0 + 1);

      // Timeout: device never clocks
      start(16'h00AA);
      wait_req();
      k = 0;
      seen = 1'b0;
      for (int i = 0; i < TMO + 20 && !seen; i++) begin
         @(posedge clk);
         #1 k++;
         if (tx_err) seen = 1'b1;
      end
      chk("timeout_seen", seen, 1);
      chk("timeout_cycles", k, TMO);
      chk("timeout_clk_oe", ps2_clk_oe, 0);
      chk("timeout_data_oe", ps2_data_oe, 0);
      chk("timeout_busy", tx_busy, 0);

      // Reset in the middle of SHIFT
      start(16'hED02);
      wait_req();
      dev_byte({1'b1, 1'b1, 8'hED}, 1'b1, 3);
      repeat (4) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (3) @(negedge clk);
      e0 = err_cnt;
      d0 = done_cnt;
      rst_b = 1'b0;
      #1;
      chk("midrst_clk_oe", ps2_clk_oe, 0);
      chk("midrst_data_oe", ps2_data_oe, 0);
      chk("midrst_busy", tx_busy, 0);
      repeat (3) @(posedge clk);
      #1 chk("midrst_data_oe_hold", ps2_data_oe, 0);
      @(negedge clk);
      rst_b = 1'b1;
      dev_clk_low = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("postrst_busy", tx_busy, 0);
      chk("postrst_clk_oe", ps2_clk_oe, 0);
      chk("postrst_data_oe", ps2_data_oe, 0);
      chk("postrst_no_err", err_cnt, e0);
      chk("postrst_no_done", done_cnt, d0);

      chk("never_both_oe", glitch_cnt, 0);
      chk("busy_pulse_align", align_bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
